// File: rtl/gpc_imem_responder.sv
// Instruction-memory responder for the Gwen Processor Core fetch port.
// Accepts one fetch at a time, returns the addressed word (or an ebreak on
// a bad address) after LATENCY cycles, and exposes a program-load write port.
module gpc_imem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic        rsp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [31:0] EBREAK     = 32'h0010_0073;
    localparam logic [2:0]  WAIT_INIT  = 3'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;          // word captured at accept
    logic        err_q, err_d;            // error captured at accept
    logic [31:0] rsp_inst_q, rsp_inst_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   req_off, load_off;
    logic [AW-1:0] req_idx, load_idx;
    logic          req_err, load_ok, accept;
    logic [31:0]   fetch_word;

    assign req_ready = rst && (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_inst  = rsp_inst_q;
    assign rsp_err   = rsp_err_q;

    // Address decode for the fetch and load ports (offsets wrap at 32 bits).
    always_comb begin
        req_off    = req_addr - ADDR_BASE;
        req_err    = (req_addr[1:0] != 2'b00) || (req_off >= SPAN_BYTES);
        req_idx    = req_off[AW+1:2];
        fetch_word = req_err ? EBREAK : mem[req_idx];
        load_off   = load_addr - ADDR_BASE;
        load_ok    = load_en && (load_addr[1:0] == 2'b00) && (load_off < SPAN_BYTES);
        load_idx   = load_off[AW+1:2];
    end

    // Program store write port; old data is read by a same-edge accept.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_idx] <= load_data;
        end
    end

    // Next-state and response-register logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        err_d      = err_q;
        rsp_inst_d = rsp_inst_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d = fetch_word;
                    err_d  = req_err;
                    if (LATENCY == 1) begin
                        // Single-cycle latency bypasses the capture registers.
                        state_d    = RESP;
                        rsp_inst_d = fetch_word;
                        rsp_err_d  = req_err;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d    = RESP;
                    rsp_inst_d = data_q;
                    rsp_err_d  = err_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            rsp_inst_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            err_q      <= err_d;
            rsp_inst_q <= rsp_inst_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_gpc_imem_responder.sv
// Directed bench for gpc_imem_responder: four instances at LATENCY 1,3,4,2.
module tb_gpc_imem_responder;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic [31:0] req_addr  [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [31:0] rsp_inst  [NI];
    logic        rsp_err   [NI];
    logic        load_en   [NI];
    logic [31:0] load_addr [NI];
    logic [31:0] load_data [NI];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used to time accepts.
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        gpc_imem_responder #(
            .ADDR_BASE  (32'h8000_0000),
            .DEPTH_WORDS(1024),
            .LATENCY    ((g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 2)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_addr (req_addr[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_inst (rsp_inst[g]),
            .rsp_err  (rsp_err[g]),
            .load_en  (load_en[g]),
            .load_addr(load_addr[g]),
            .load_data(load_data[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : (k == 2) ? 4 : 2;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [31:0] a, input logic [31:0] d);
        load_en[k] = 1'b1; load_addr[k] = a; load_data[k] = d;
        tick();
        load_en[k] = 1'b0;
    endtask

    // One complete fetch; optionally loads the same address at the accept edge.
    task automatic fetch(input int k, input logic [31:0] a, input bit ld, input logic [31:0] ldd,
                         output logic [31:0] inst, output logic err);
        int lat;
        req_valid[k] = 1'b1; req_addr[k] = a;
        if (ld) begin
            load_en[k] = 1'b1; load_addr[k] = a; load_data[k] = ldd;
        end
        check_eq("req_ready_idle", 32'(req_ready[k]), 32'd1);
        tick();
        req_valid[k] = 1'b0; load_en[k] = 1'b0;
        lat = 1;
        while (!rsp_valid[k] && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(lat_of(k)));
        inst = rsp_inst[k]; err = rsp_err[k];
        rsp_ready[k] = 1'b1;
        tick();
        rsp_ready[k] = 1'b0;
        check_eq("rsp_valid_drop", 32'(rsp_valid[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] inst, inst0;
        logic        err, err0;
        int          wait_n;
        int          acc [8];
        logic [31:0] words [8];

        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 1'b0; req_addr[k] = '0; rsp_ready[k] = 1'b0;
            load_en[k] = 1'b0; load_addr[k] = '0; load_data[k] = '0;
        end
        tick(); tick();
        for (int k = 0; k < NI; k++) begin
            check_eq("rst_req_ready", 32'(req_ready[k]), 32'd0);
            check_eq("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check_eq("rst_rsp_inst", rsp_inst[k], 32'd0);
            check_eq("rst_rsp_err", 32'(rsp_err[k]), 32'd0);
        end
        rst = 1'b1;
        #1;

        // Preload every instance.
        for (int k = 0; k < NI; k++) begin
            load(k, 32'h8000_0000, 32'h0050_0093);
            load(k, 32'h8000_0004, 32'h0010_0073);
            load(k, 32'h8000_0008, 32'h1111_1111);
            load(k, 32'h8000_0FFC, 32'hCAFE_F00D);
        end
        for (int i = 0; i < 8; i++) load(3, 32'h8000_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        // Misaligned and out-of-range loads must be dropped (both alias word 1).
        load(0, 32'h8000_0006, 32'h5555_5555);
        load(0, 32'h8000_1004, 32'h6666_6666);

        // LATENCY=1 basic fetches.
        fetch(0, 32'h8000_0000, 1'b0, '0, inst, err);
        check_eq("l1_w0_inst", inst, 32'h0050_0093);
        check_eq("l1_w0_err", 32'(err), 32'd0);
        fetch(0, 32'h8000_0004, 1'b0, '0, inst, err);
        check_eq("l1_w1_inst", inst, 32'h0010_0073);
        check_eq("l1_w1_err", 32'(err), 32'd0);
        fetch(0, 32'h8000_0FFC, 1'b0, '0, inst, err);
        check_eq("last_word_inst", inst, 32'hCAFE_F00D);
        check_eq("last_word_err", 32'(err), 32'd0);

        // Error cases.
        fetch(0, 32'h8000_0002, 1'b0, '0, inst, err);
        check_eq("misalign_err", 32'(err), 32'd1);
        check_eq("misalign_inst", inst, 32'h0010_0073);
        fetch(0, 32'h7FFF_FFFC, 1'b0, '0, inst, err);
        check_eq("below_base_err", 32'(err), 32'd1);
        check_eq("below_base_inst", inst, 32'h0010_0073);
        fetch(0, 32'h8000_1000, 1'b0, '0, inst, err);
        check_eq("past_end_err", 32'(err), 32'd1);
        check_eq("past_end_inst", inst, 32'h0010_0073);

        // Same-edge load and accept: old data, then new data.
        fetch(0, 32'h8000_0008, 1'b1, 32'hDEAD_BEEF, inst, err);
        check_eq("rbw_old", inst, 32'h1111_1111);
        fetch(0, 32'h8000_0008, 1'b0, '0, inst, err);
        check_eq("rbw_new", inst, 32'hDEAD_BEEF);

        // LATENCY=3 timing and hold under backpressure.
        req_valid[1] = 1'b1; req_addr[1] = 32'h8000_0000;
        tick();
        req_valid[1] = 1'b0;
        check_eq("l3_e1_valid", 32'(rsp_valid[1]), 32'd0);
        tick();
        check_eq("l3_e2_valid", 32'(rsp_valid[1]), 32'd0);
        tick();
        check_eq("l3_e3_valid", 32'(rsp_valid[1]), 32'd1);
        inst0 = rsp_inst[1]; err0 = rsp_err[1];
        check_eq("l3_inst", inst0, 32'h0050_0093);
        check_eq("l3_err", 32'(err0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("hold_inst", rsp_inst[1], 32'h0050_0093);
            check_eq("hold_err", 32'(rsp_err[1]), 32'd0);
            check_eq("hold_valid", 32'(rsp_valid[1]), 32'd1);
            check_eq("hold_req_ready", 32'(req_ready[1]), 32'd0);
        end
        rsp_ready[1] = 1'b1;
        tick();
        rsp_ready[1] = 1'b0;
        check_eq("l3_drop", 32'(rsp_valid[1]), 32'd0);
        check_eq("l3_inst_kept", rsp_inst[1], 32'h0050_0093);
        fetch(1, 32'h8000_0004, 1'b0, '0, inst, err);
        check_eq("l3_w1_inst", inst, 32'h0010_0073);

        // Reset during WAIT on the LATENCY=4 instance.
        req_valid[2] = 1'b1; req_addr[2] = 32'h8000_0000;
        tick();
        req_valid[2] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_eq("rst_mid_req_ready", 32'(req_ready[2]), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check_eq("rst_mid_no_rsp", 32'(rsp_valid[2]), 32'd0);
            tick();
        end
        fetch(2, 32'h8000_0004, 1'b0, '0, inst, err);
        check_eq("after_rst_inst", inst, 32'h0010_0073);
        check_eq("after_rst_err", 32'(err), 32'd0);

        // Streaming with rsp_ready tied high on the LATENCY=2 instance.
        rsp_ready[3] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid[3] = 1'b1; req_addr[3] = 32'h8000_0100 + 32'(4 * i);
            wait_n = 0;
            while (!req_ready[3] && wait_n < 20) begin
                tick();
                wait_n++;
            end
            tick();
            acc[i] = cyc;
            req_valid[3] = 1'b0;
            wait_n = 0;
            while (!rsp_valid[3] && wait_n < 20) begin
                tick();
                wait_n++;
            end
            words[i] = rsp_inst[3];
        end
        tick();
        rsp_ready[3] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq("stream_word", words[i], 32'hA000_0000 + 32'(i));
            if (i > 0) check_eq("stream_period", 32'(acc[i] - acc[i-1]), 32'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpc_imem_responder.md
Name: gpc_imem_responder

Overview:
- Instruction-memory responder on the fetch interface of the Gwen Processor Core.
- The core drives a fetch address (pc) and consumes the returned 32-bit instruction; this block is the memory end of that exchange.
- Accepts one fetch request at a time over a valid/ready handshake and returns the addressed word after a programmable latency, with an error flag.
- Holds a word-addressed program store with a simple load port, used by the simulation harness to preload code.

Parameters:
- ADDR_BASE, 32'h80000000, byte address of word 0 (the core's reset pc).
- DEPTH_WORDS, 1024, number of 32-bit words in the store; power of two, 16..65536.
- LATENCY, 1, cycles from request acceptance to first cycle of rsp_valid; legal range 1..7.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- req_valid  input  1  fetch request valid.
- req_ready  output  1  block can accept a request.
- req_addr  input  32  fetch byte address (pc).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  core accepts the response.
- rsp_inst  output  32  returned instruction word.
- rsp_err  output  1  request was misaligned or out of range.
- load_en  input  1  program-load write strobe.
- load_addr  input  32  program-load byte address.
- load_data  input  32  program-load word.

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE, rsp_valid=0, rsp_inst=0, rsp_err=0, latency counter=0.
  - req_ready=0 while rst=0.
  - Store contents are not cleared.
- States: IDLE, WAIT, RESP. req_ready=1 only in IDLE with rst=1, so at most one request is outstanding.
- IDLE: when req_valid and req_ready are both 1 at an edge (accept), the block does all of the following at that edge:
  - Computes off=req_addr-ADDR_BASE (32-bit wrap) and sets err=(req_addr[1:0]!=0) or (off>=DEPTH_WORDS*4).
  - Reads store word off[.. :2] at that edge.
  - Transitions: LATENCY=1 goes to RESP; otherwise goes to WAIT with counter=LATENCY-2.
- WAIT: counter decrements each edge; at the edge where counter==0, go to RESP.
- Timing: a request accepted at edge E gives rsp_valid=1 from edge E+LATENCY onward.
- RESP outputs:
  - rsp_valid=1, rsp_err=err.
  - rsp_inst=read word if err=0, else 32'h00100073 (ebreak encoding), so a runaway pc halts the core.
  - rsp_inst and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
- RESP handshake: on an edge with rsp_ready=1, rsp_valid goes to 0, rsp_inst holds its last value, and state returns to IDLE. Earliest next accept is the following edge, so back-to-back fetches take LATENCY+1 cycles each.
- Inputs ignored: req_valid and req_addr outside IDLE; rsp_ready outside RESP.
- Load port:
  - When load_en=1 with an aligned, in-range load_addr, the store word is written at the edge; this is independent of state.
  - Misaligned or out-of-range loads are silently dropped.
  - A load and an accept to the same word at the same edge return the old data (read-before-write).
  - Loads to the word of an in-flight request do not change its already-captured response.
- Reset mid-operation: any WAIT or RESP transaction is discarded without a response, and state returns to IDLE.
- Arithmetic: the range check uses unsigned 32-bit compare on off. An address below ADDR_BASE wraps to a large off and is flagged as an error.

Test Plan:
- Preload 0x80000000 <- 0x00500093 and 0x80000004 <- 0x00100073; LATENCY=1; fetch 0x80000000 accepted at edge E -> rsp_valid=1 at E+1 with rsp_inst=0x00500093, rsp_err=0; fetch 0x80000004 -> 0x00100073.
- LATENCY=3, accept at edge E -> rsp_valid=0 at E+1 and E+2, 1 at E+3; hold rsp_ready=0 for 4 cycles -> rsp_inst and rsp_err stay constant and req_ready stays 0.
- Fetch 0x80000002 -> rsp_err=1, rsp_inst=0x00100073. Fetch 0x7FFFFFFC -> rsp_err=1. Fetch 0x80001000 with DEPTH_WORDS=1024 -> rsp_err=1.
- Same-edge load of 0xDEADBEEF to 0x80000008 (old value 0x11111111) and accept of 0x80000008 -> rsp_inst=0x11111111; next fetch of that address -> 0xDEADBEEF.
- Assert rst=0 for one edge while in WAIT (LATENCY=4) -> rsp_valid never rises for that request; req_ready=1 the edge after rst returns to 1; a new fetch completes normally.
- Stream 8 sequential fetches with rsp_ready tied to 1, LATENCY=2 -> each takes exactly 3 cycles from accept to next accept, and the words are returned in address order.
